// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port with a busy scoreboard.
// Optional WB_BYPASS_EN macro enables the write-port bypass outputs.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  input  logic                    rsv_valid,
  input  logic [4:0]              rsv_addr,
  input  logic                    flush,
  input  logic [4:0]              rd_ad1,
  input  logic [4:0]              rd_ad2,
  output logic                    busy1,
  output logic                    busy2,
  output logic                    we3,
  output logic [4:0]              ad3,
  output logic [XLEN-1:0]         wd3,
  output logic                    fwd1_valid,
  output logic                    fwd2_valid,
  output logic [XLEN-1:0]         fwd_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [31:0]     busy;
  logic [31:0]     busy_nxt;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [4:0]      gnt_addr;
  logic [XLEN-1:0] gnt_data;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Search starts just after the last winner; reset holds every ready low.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_any && req_valid[wrap(rr_ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap(rr_ptr, k);
      end
    end
    gnt_any = gnt_any & rst_n;
  end

  always_comb begin
    req_ready = '0;
    gnt_addr  = '0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && gnt_idx == PW'(i)) begin
        req_ready[i] = 1'b1;
        gnt_addr     = req_addr[5*i +: 5];
        gnt_data     = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // Release first so a same-edge reservation of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (gnt_any && gnt_addr != 5'd0)
      busy_nxt[gnt_addr] = 1'b0;
    if (flush)
      busy_nxt = '0;
    else if (rsv_valid && rsv_addr != 5'd0)
      busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PW'(NUM_REQ - 1);
      busy   <= '0;
    end else begin
      busy <= busy_nxt;
      if (gnt_any)
        rr_ptr <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      ad3 <= '0;
      wd3 <= '0;
    end else if (gnt_any) begin
      we3 <= (gnt_addr != 5'd0);
      ad3 <= gnt_addr;
      wd3 <= gnt_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  assign busy1 = busy[rd_ad1];
  assign busy2 = busy[rd_ad2];

`ifdef WB_BYPASS_EN
  assign fwd1_valid = we3 && ad3 == rd_ad1 && rd_ad1 != 5'd0;
  assign fwd2_valid = we3 && ad3 == rd_ad2 && rd_ad2 != 5'd0;
  assign fwd_data   = wd3;
`else
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, corner sequences, random
// traffic against a behavioural model of the write port and scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic [4:0]  rd_ad1;
  logic [4:0]  rd_ad2;
  logic        busy1;
  logic        busy2;
  logic        we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;
  logic        fwd1_valid;
  logic        fwd2_valid;
  logic [31:0] fwd_data;

  regfile_wb_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .flush(flush),
    .rd_ad1(rd_ad1), .rd_ad2(rd_ad2),
    .busy1(busy1), .busy2(busy2),
    .we3(we3), .ad3(ad3), .wd3(wd3),
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Behavioural model
  int          m_rr;
  bit [31:0]   m_busy;
  bit          m_we;
  bit [4:0]    m_ad;
  bit [31:0]   m_wd;

  task automatic m_reset();
    m_rr = 1; m_busy = '0; m_we = 0; m_ad = '0; m_wd = '0;
  endtask

  function automatic int m_grant();
    for (int k = 1; k <= 2; k++) begin
      int i;
      i = (m_rr + k) % 2;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(output logic [1:0] rdy_seen);
    int g;
    logic [4:0] a;
    logic e1, e2;
    #1;
    g = m_grant();
    chk("req_ready", {62'b0, req_ready}, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("busy1", {63'b0, busy1}, {63'b0, m_busy[rd_ad1]});
    chk("busy2", {63'b0, busy2}, {63'b0, m_busy[rd_ad2]});
    e1 = BYP && m_we && m_ad == rd_ad1 && rd_ad1 != 0;
    e2 = BYP && m_we && m_ad == rd_ad2 && rd_ad2 != 0;
    chk("fwd1_valid", {63'b0, fwd1_valid}, {63'b0, e1});
    chk("fwd2_valid", {63'b0, fwd2_valid}, {63'b0, e2});
    chk("fwd_data", {32'b0, fwd_data}, BYP ? {32'b0, m_wd} : 64'd0);
    rdy_seen = req_ready;
    @(posedge clk);
    if (g >= 0) begin
      m_rr = g;
      a = req_addr[5*g +: 5];
      m_we = (a != 0);
      m_ad = a;
      m_wd = req_data[32*g +: 32];
      if (a != 0) m_busy[a] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (flush) m_busy = '0;
    else if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    #1;
    chk("we3", {63'b0, we3}, {63'b0, m_we});
    chk("ad3", {59'b0, ad3}, {59'b0, m_ad});
    chk("wd3", {32'b0, wd3}, {32'b0, m_wd});
  endtask

  typedef struct {
    logic [1:0] vld;
    logic [4:0] a0;
    logic [4:0] a1;
    logic       rv;
    logic [4:0] ra;
    logic       fl;
    logic [4:0] rd1;
    logic [1:0] rdy;
    logic       we;
    logic [4:0] ad;
    logic       b1;
  } vec_t;

  vec_t tbl[16];

  task automatic set_in(input logic [1:0] v, input logic [4:0] a0,
                        input logic [4:0] a1, input logic rv,
                        input logic [4:0] ra, input logic fl,
                        input logic [4:0] r1, input logic [4:0] r2);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {32'hB000_0000 | {27'b0, a1}, 32'hA000_0000 | {27'b0, a0}};
    rsv_valid = rv;
    rsv_addr  = ra;
    flush     = fl;
    rd_ad1    = r1;
    rd_ad2    = r2;
  endtask

  initial begin
    logic [1:0] rdy;
    //          vld    a0  a1  rv ra  fl rd1  rdy    we ad  b1
    tbl[0]  = '{2'b11, 5,  6,  0, 0,  0, 5,   2'b01, 1, 5,  0};
    tbl[1]  = '{2'b11, 5,  6,  0, 0,  0, 5,   2'b10, 1, 6,  0};
    tbl[2]  = '{2'b11, 5,  6,  0, 0,  0, 5,   2'b01, 1, 5,  0};
    tbl[3]  = '{2'b11, 5,  6,  0, 0,  0, 5,   2'b10, 1, 6,  0};
    tbl[4]  = '{2'b00, 0,  0,  1, 7,  0, 7,   2'b00, 0, 6,  1};
    tbl[5]  = '{2'b01, 7,  0,  0, 0,  0, 7,   2'b01, 1, 7,  0};
    tbl[6]  = '{2'b01, 7,  0,  1, 7,  0, 7,   2'b01, 1, 7,  1};
    tbl[7]  = '{2'b10, 0,  0,  0, 0,  0, 7,   2'b10, 0, 0,  1};
    tbl[8]  = '{2'b00, 0,  0,  1, 3,  0, 3,   2'b00, 0, 0,  1};
    tbl[9]  = '{2'b00, 0,  0,  1, 4,  0, 4,   2'b00, 0, 0,  1};
    tbl[10] = '{2'b00, 0,  0,  1, 9,  0, 9,   2'b00, 0, 0,  1};
    tbl[11] = '{2'b01, 12, 0,  1, 9,  1, 9,   2'b01, 1, 12, 0};
    tbl[12] = '{2'b00, 0,  0,  0, 0,  0, 3,   2'b00, 0, 12, 0};
    tbl[13] = '{2'b00, 0,  0,  0, 0,  0, 7,   2'b00, 0, 12, 0};
    tbl[14] = '{2'b00, 0,  0,  1, 0,  0, 0,   2'b00, 0, 12, 0};
    tbl[15] = '{2'b11, 1,  2,  0, 0,  0, 0,   2'b10, 1, 2,  0};

    // Reset state, with requests pending to show ready stays low
    rst_n = 1'b0;
    set_in(2'b11, 5, 6, 1, 8, 0, 8, 0);
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {62'b0, req_ready}, 64'd0);
    chk("rst_we3", {63'b0, we3}, 64'd0);
    chk("rst_ad3", {59'b0, ad3}, 64'd0);
    chk("rst_wd3", {32'b0, wd3}, 64'd0);
    chk("rst_busy1", {63'b0, busy1}, 64'd0);
    chk("rst_fwd1", {63'b0, fwd1_valid}, 64'd0);
    set_in(2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].vld, tbl[i].a0, tbl[i].a1, tbl[i].rv, tbl[i].ra,
             tbl[i].fl, tbl[i].rd1, 5'd0);
      cycle(rdy);
      chk($sformatf("tbl%0d_ready", i), {62'b0, rdy}, {62'b0, tbl[i].rdy});
      chk($sformatf("tbl%0d_we3", i), {63'b0, we3}, {63'b0, tbl[i].we});
      chk($sformatf("tbl%0d_ad3", i), {59'b0, ad3}, {59'b0, tbl[i].ad});
      chk($sformatf("tbl%0d_busy1", i), {63'b0, busy1}, {63'b0, tbl[i].b1});
    end

    // x0 write with a distinctive payload still hands over the pointer
    set_in(2'b10, 0, 0, 0, 0, 0, 0, 0);
    req_data[63:32] = 32'hDEAD_BEEF;
    cycle(rdy);
    chk("x0_ready", {62'b0, rdy}, 64'd2);
    chk("x0_we3", {63'b0, we3}, 64'd0);
    set_in(2'b11, 5, 6, 0, 0, 0, 0, 0);
    cycle(rdy);
    chk("x0_next_ready", {62'b0, rdy}, 64'd1);

    // Reset in the middle of a grant
    set_in(2'b11, 5, 6, 1, 8, 0, 8, 0);
    cycle(rdy);
    chk("pre_rst_we3", {63'b0, we3}, 64'd1);
    chk("pre_rst_busy8", {63'b0, busy1}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we3", {63'b0, we3}, 64'd0);
    chk("mid_rst_busy1", {63'b0, busy1}, 64'd0);
    chk("mid_rst_ready", {62'b0, req_ready}, 64'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rsv_valid = 1'b0;
    #1;
    chk("post_rst_ready", {62'b0, req_ready}, 64'd1);
    cycle(rdy);

    // Bypass of the pending write
    set_in(2'b01, 10, 0, 0, 0, 0, 10, 10);
    req_data[31:0] = 32'h1234_5678;
    cycle(rdy);
    set_in(2'b00, 0, 0, 0, 0, 0, 10, 10);
    #1;
    chk("byp_fwd1", {63'b0, fwd1_valid}, {63'b0, BYP});
    chk("byp_data", {32'b0, fwd_data}, BYP ? 64'h1234_5678 : 64'd0);
    cycle(rdy);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_in(2'($urandom), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      req_data = {$urandom, $urandom};
      cycle(rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
